conv_operand_feeder: RTL

CONV_OPERAND_FEEDER -- requirements
Module: conv_operand_feeder

---
 rtl/conv_pkg.sv | 40 ++++
 rtl/conv_operand_ram.sv | 36 +++
 rtl/conv_operand_feeder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared sizes, state encoding and window-bound helpers for the convolution operand feeder
//
// Contents:
//   DATA_W, SIG_DEPTH, KER_DEPTH : default operand width and buffer depths
//   state_t                      : sequencer states IDLE, RUN, FINISH
//   kFirst / kLast               : first and last kernel tap of output window n

package conv_pkg;

    localparam int DATA_W    = 8;
    localparam int SIG_DEPTH = 16;
    localparam int KER_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    // max(0, n - sigLen + 1); computed as (n + 1) - sigLen to stay unsigned
    function automatic logic [2:0] kFirst(input logic [4:0] n, input logic [4:0] sigLen);
        logic [5:0] nPlus1;
        nPlus1 = {1'b0, n} + 6'd1;
        if (nPlus1 > {1'b0, sigLen}) begin
            return 3'(nPlus1 - {1'b0, sigLen});
        end
        return 3'd0;
    endfunction

    // min(n, kerLen - 1)
    function automatic logic [2:0] kLast(input logic [4:0] n, input logic [3:0] kerLen);
        logic [4:0] kerMax;
        kerMax = {1'b0, kerLen} - 5'd1;
        if (n < kerMax) begin
            return 3'(n);
        end
        return 3'(kerMax);
    endfunction

endpackage

// File: rtl/conv_operand_ram.sv
// rtl/conv_operand_ram.sv - operand buffer with synchronous write and combinational read
//
// Ports:
//   Clk     in  write clock
//   WrEn    in  write strobe
//   WrAddr  in  write address
//   WrData  in  write data
//   RdAddr  in  read address
//   RdData  out read data (combinational)
//
// Contents are deliberately not reset; they persist until rewritten.

module conv_operand_ram #(
    parameter int DATA_W = conv_pkg::DATA_W,
    parameter int DEPTH  = conv_pkg::SIG_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    input  logic [ADDR_W-1:0] RdAddr,
    output logic [DATA_W-1:0] RdData
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (WrEn) begin
            mem[WrAddr] <= WrData;
        end
    end

    assign RdData = mem[RdAddr];

endmodule

// File: rtl/conv_operand_feeder.sv
// rtl/conv_operand_feeder.sv - sequences signal/kernel operand pairs for a 1-D convolution MAC
//
// Ports:
//   Clk, Reset        in  clock, asynchronous active-high reset
//   LoadSig, LoadKer  in  write LoadData into signal[LoadAddr] / kernel[LoadAddr[2:0]] (ignored while Busy)
//   LoadAddr, LoadData in buffer write address and data
//   SigLen, KerLen    in  run lengths (1..16, 1..8), latched when Start is accepted
//   Start             in  begin a run (ignored while Busy or with an illegal length)
//   Stall             in  freeze sequencing and outputs while high in RUN
//   Busy              out run in progress (RUN and FINISH)
//   x, y              out signal[n-k] and kernel[k]
//   XYValid           out x/y pair valid
//   AccumReset        out first pair of output window n
//   WindowLast        out last pair of output window n
//   OutIndex          out output sample index n
//   Done              out one-cycle pulse after the final pair

module conv_operand_feeder #(
    parameter int DATA_W    = conv_pkg::DATA_W,
    parameter int SIG_DEPTH = conv_pkg::SIG_DEPTH,
    parameter int KER_DEPTH = conv_pkg::KER_DEPTH
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              LoadSig,
    input  logic              LoadKer,
    input  logic [3:0]        LoadAddr,
    input  logic [DATA_W-1:0] LoadData,
    input  logic [4:0]        SigLen,
    input  logic [3:0]        KerLen,
    input  logic              Start,
    input  logic              Stall,
    output logic              Busy,
    output logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] y,
    output logic              XYValid,
    output logic              AccumReset,
    output logic              WindowLast,
    output logic [4:0]        OutIndex,
    output logic              Done
);

    import conv_pkg::*;

    localparam int SIG_AW = $clog2(SIG_DEPTH);
    localparam int KER_AW = $clog2(KER_DEPTH);

    state_t            state, stateNext;
    logic [4:0]        nCnt, nNext;
    logic [2:0]        kCnt, kNext;
    logic [4:0]        sigLenQ, sigLenNext;
    logic [3:0]        kerLenQ, kerLenNext;
    // set once the final pair has been issued; the next unstalled cycle ends the run
    logic              lastIssued, lastIssuedNext;

    logic              busyNext, doneNext, validNext, accumResetNext, windowLastNext;
    logic [DATA_W-1:0] xNext, yNext;
    logic [4:0]        outIndexNext;

    logic [SIG_AW-1:0] sigRdAddr;
    logic [KER_AW-1:0] kerRdAddr;
    logic [DATA_W-1:0] sigRdData, kerRdData;

    logic              lenOk;
    logic [2:0]        kLo, kHi;
    logic [4:0]        nFinal;
    logic [4:0]        nInc;

    // Buffers

    conv_operand_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (SIG_DEPTH),
        .ADDR_W (SIG_AW)
    ) u_sigRam (
        .Clk    (Clk),
        .WrEn   (LoadSig && !Busy),
        .WrAddr (SIG_AW'(LoadAddr)),
        .WrData (LoadData),
        .RdAddr (sigRdAddr),
        .RdData (sigRdData)
    );

    conv_operand_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (KER_DEPTH),
        .ADDR_W (KER_AW)
    ) u_kerRam (
        .Clk    (Clk),
        .WrEn   (LoadKer && !Busy),
        .WrAddr (KER_AW'(LoadAddr)),
        .WrData (LoadData),
        .RdAddr (kerRdAddr),
        .RdData (kerRdData)
    );

    // Window arithmetic for the pair held in the counters

    assign sigRdAddr = SIG_AW'(nCnt - {2'b00, kCnt});
    assign kerRdAddr = KER_AW'(kCnt);

    assign lenOk  = (SigLen != 5'd0) && (SigLen <= 5'd16) && (KerLen != 4'd0) && (KerLen <= 4'd8);
    assign kLo    = kFirst(nCnt, sigLenQ);
    assign kHi    = kLast(nCnt, kerLenQ);
    assign nFinal = 5'(sigLenQ + {1'b0, kerLenQ} - 5'd2);
    assign nInc   = 5'(nCnt + 5'd1);

    // Next-state and next-output logic; every output is registered below

    always_comb begin
        stateNext      = state;
        nNext          = nCnt;
        kNext          = kCnt;
        sigLenNext     = sigLenQ;
        kerLenNext     = kerLenQ;
        lastIssuedNext = lastIssued;
        busyNext       = Busy;
        doneNext       = 1'b0;
        xNext          = '0;
        yNext          = '0;
        validNext      = 1'b0;
        accumResetNext = 1'b0;
        windowLastNext = 1'b0;
        outIndexNext   = 5'd0;

        case (state)
            IDLE: begin
                if (Start && lenOk) begin
                    stateNext      = RUN;
                    busyNext       = 1'b1;
                    sigLenNext     = SigLen;
                    kerLenNext     = KerLen;
                    nNext          = 5'd0;
                    kNext          = 3'd0;
                    lastIssuedNext = 1'b0;
                end
            end

            RUN: begin
                if (Stall) begin
                    // Hold the presented pair; the downstream MAC gates on Stall
                    xNext          = x;
                    yNext          = y;
                    validNext      = XYValid;
                    accumResetNext = AccumReset;
                    windowLastNext = WindowLast;
                    outIndexNext   = OutIndex;
                end else if (lastIssued) begin
                    stateNext = FINISH;
                    doneNext  = 1'b1;
                end else begin
                    xNext          = sigRdData;
                    yNext          = kerRdData;
                    validNext      = 1'b1;
                    accumResetNext = (kCnt == kLo);
                    windowLastNext = (kCnt == kHi);
                    outIndexNext   = nCnt;
                    if (kCnt == kHi) begin
                        if (nCnt == nFinal) begin
                            lastIssuedNext = 1'b1;
                        end else begin
                            nNext = nInc;
                            kNext = kFirst(nInc, sigLenQ);
                        end
                    end else begin
                        kNext = 3'(kCnt + 3'd1);
                    end
                end
            end

            FINISH: begin
                stateNext = IDLE;
                busyNext  = 1'b0;
            end

            default: begin
                stateNext = IDLE;
                busyNext  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            nCnt       <= 5'd0;
            kCnt       <= 3'd0;
            sigLenQ    <= 5'd0;
            kerLenQ    <= 4'd0;
            lastIssued <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            x          <= '0;
            y          <= '0;
            XYValid    <= 1'b0;
            AccumReset <= 1'b0;
            WindowLast <= 1'b0;
            OutIndex   <= 5'd0;
        end else begin
            state      <= stateNext;
            nCnt       <= nNext;
            kCnt       <= kNext;
            sigLenQ    <= sigLenNext;
            kerLenQ    <= kerLenNext;
            lastIssued <= lastIssuedNext;
            Busy       <= busyNext;
            Done       <= doneNext;
            x          <= xNext;
            y          <= yNext;
            XYValid    <= validNext;
            AccumReset <= accumResetNext;
            WindowLast <= windowLastNext;
            OutIndex   <= outIndexNext;
        end
    end

endmodule
